// File: rtl/hazard_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : hazard_pkg                                                   |
// | Description : Shared types and defaults for the hazard/stall controller.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

  localparam int C_REG_W_DEFAULT = 5;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_lu_detect.sv
// +----------------------------------------------------------------------------+
// | Module      : hazard_lu_detect                                             |
// | Description : Combinational load-use hazard comparator (x0 never hazards). |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_lu_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = C_REG_W_DEFAULT
) (
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_rs1_used,
  input  logic             i_rs2_used,
  input  logic             i_mem_read,
  input  logic [REG_W-1:0] i_rd,
  output logic             o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_rs1_used && (i_rs1 == i_rd);
  assign w_rs2_hit  = i_rs2_used && (i_rs2 == i_rd);
  assign o_load_use = i_mem_read && (i_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : hazard_stall_ctrl                                            |
// | Description : PC / IF/ID / ID/EX write-enable and flush control with       |
// |               mul/div wait FSM. HAZARD_PERF_CNT_EN adds perf counters.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W      = C_REG_W_DEFAULT,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IFID_Rs1,
  input  logic [REG_W-1:0] IFID_Rs2,
  input  logic             IFID_Rs1_Used,
  input  logic             IFID_Rs2_Used,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rd,
  input  logic             Branch_Taken,
  input  logic             MulDiv_Start,
  input  logic             MulDiv_Done,
  input  logic             IMem_Ready,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Flush,
  output logic             MD_Error
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      Stall_Cycles,
  output logic [31:0]      Flush_Count
`endif
);

  localparam int               CNT_W      = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_md_error;
  logic             w_set_error;
  logic             w_load_use;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_idex_write;
  logic             w_idex_flush;

  hazard_lu_detect #(
    .REG_W (REG_W)
  ) u_lu_detect (
    .i_rs1      (IFID_Rs1),
    .i_rs2      (IFID_Rs2),
    .i_rs1_used (IFID_Rs1_Used),
    .i_rs2_used (IFID_Rs2_Used),
    .i_mem_read (IDEX_MemRead),
    .i_rd       (IDEX_Rd),
    .o_load_use (w_load_use)
  );

  always_comb begin
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_write = 1'b1;
    w_idex_flush = 1'b0;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_set_error  = 1'b0;

    if (rst) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_write = 1'b0;
      w_state_nxt  = RUN;
      w_cnt_nxt    = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (Branch_Taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end else if (MulDiv_Start) begin
            // Start with Done in the same cycle is a single-cycle op
            if (!MulDiv_Done) begin
              w_state_nxt = MD_WAIT;
            end
            w_cnt_nxt = '0;
          end else if (w_load_use || !IMem_Ready) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (MulDiv_Done || (r_cnt == C_CNT_LAST)) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
            w_set_error = !MulDiv_Done;
          end else begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_write = 1'b0;
            w_cnt_nxt    = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_md_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_set_error) begin
        r_md_error <= 1'b1;
      end
    end
  end

  assign PC_Write   = w_pc_write;
  assign IFID_Write = w_ifid_write;
  assign IFID_Flush = w_ifid_flush;
  assign IDEX_Write = w_idex_write;
  assign IDEX_Flush = w_idex_flush;
  assign MD_Error   = r_md_error;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_pc_write) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if ((r_state == RUN) && Branch_Taken) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign Stall_Cycles = r_stall_cycles;
  assign Flush_Count  = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_stall_ctrl                                         |
// | Description : Scoreboard bench for hazard_stall_ctrl (MD_TIMEOUT = 8).     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_stall_ctrl;

  localparam int REG_W      = 5;
  localparam int MD_TIMEOUT = 8;

  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush}
  localparam logic [4:0] C_DEF   = 5'b11010;
  localparam logic [4:0] C_BR    = 5'b11111;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_HOLD  = 5'b00000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REG_W-1:0] IFID_Rs1, IFID_Rs2, IDEX_Rd;
  logic             IFID_Rs1_Used, IFID_Rs2_Used, IDEX_MemRead;
  logic             Branch_Taken, MulDiv_Start, MulDiv_Done, IMem_Ready;
  logic             PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, MD_Error;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      Stall_Cycles, Flush_Count;
`endif

  logic [5:0] sb[$];
  logic [5:0] obs, expv;
  logic       exp_err = 1'b0;
  int         n_cmp   = 0;
  int         n_bad   = 0;

  hazard_stall_ctrl #(
    .REG_W      (REG_W),
    .MD_TIMEOUT (MD_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .IFID_Rs1      (IFID_Rs1),
    .IFID_Rs2      (IFID_Rs2),
    .IFID_Rs1_Used (IFID_Rs1_Used),
    .IFID_Rs2_Used (IFID_Rs2_Used),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_Rd       (IDEX_Rd),
    .Branch_Taken  (Branch_Taken),
    .MulDiv_Start  (MulDiv_Start),
    .MulDiv_Done   (MulDiv_Done),
    .IMem_Ready    (IMem_Ready),
    .PC_Write      (PC_Write),
    .IFID_Write    (IFID_Write),
    .IFID_Flush    (IFID_Flush),
    .IDEX_Write    (IDEX_Write),
    .IDEX_Flush    (IDEX_Flush),
    .MD_Error      (MD_Error)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .Stall_Cycles  (Stall_Cycles),
    .Flush_Count   (Flush_Count)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    Branch_Taken  = 1'b0;
    MulDiv_Start  = 1'b0;
    MulDiv_Done   = 1'b0;
    IMem_Ready    = 1'b1;
    IDEX_MemRead  = 1'b0;
    IDEX_Rd       = '0;
    IFID_Rs1      = '0;
    IFID_Rs2      = '0;
    IFID_Rs1_Used = 1'b0;
    IFID_Rs2_Used = 1'b0;
  endtask

  task automatic set_lu(input logic mr, input logic [REG_W-1:0] rd,
                        input logic [REG_W-1:0] rs1, input logic u1,
                        input logic [REG_W-1:0] rs2, input logic u2);
    IDEX_MemRead  = mr;
    IDEX_Rd       = rd;
    IFID_Rs1      = rs1;
    IFID_Rs1_Used = u1;
    IFID_Rs2      = rs2;
    IFID_Rs2_Used = u2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    Branch_Taken = 1'b1;
    IMem_Ready   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back({(i == 0) ? C_HOLD : C_DEF, 1'b0});
      @(negedge clk);
      obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, MD_Error};
      expv = sb.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL reset step %0d: got %b expected %b", i, obs, expv);
      end
      next_cycle();
      rst = 1'b0;
      set_idle();
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 7; i++) begin
      set_idle();
      case (i)
        0: begin set_lu(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0); sb.push_back({C_STALL, exp_err}); end
        1: sb.push_back({C_DEF, exp_err});
        2: begin set_lu(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1); sb.push_back({C_STALL, exp_err}); end
        3: begin set_lu(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0); sb.push_back({C_DEF, exp_err}); end
        4: begin set_lu(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1); sb.push_back({C_DEF, exp_err}); end
        5: begin set_lu(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1); sb.push_back({C_DEF, exp_err}); end
        default: begin IMem_Ready = 1'b0; sb.push_back({C_STALL, exp_err}); end
      endcase
      @(negedge clk);
      obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, MD_Error};
      expv = sb.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL load_use step %0d: got %b expected %b", i, obs, expv);
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_branch();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      if (i == 0) begin
        Branch_Taken = 1'b1;
        IMem_Ready   = 1'b0;
        set_lu(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        sb.push_back({C_BR, exp_err});
      end else begin
        sb.push_back({C_DEF, exp_err});
      end
      @(negedge clk);
      obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, MD_Error};
      expv = sb.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL branch step %0d: got %b expected %b", i, obs, expv);
      end
      next_cycle();
    end
  endtask

  task automatic test_md_done();
    for (int i = 0; i < 8; i++) begin
      set_idle();
      case (i)
        0: begin MulDiv_Start = 1'b1; sb.push_back({C_DEF, exp_err}); end
        2: begin Branch_Taken = 1'b1; sb.push_back({C_HOLD, exp_err}); end
        3: begin set_lu(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0); sb.push_back({C_HOLD, exp_err}); end
        4: begin IMem_Ready = 1'b0; sb.push_back({C_HOLD, exp_err}); end
        6: begin MulDiv_Done = 1'b1; sb.push_back({C_DEF, exp_err}); end
        7: begin IMem_Ready = 1'b0; sb.push_back({C_STALL, exp_err}); end
        default: sb.push_back({C_HOLD, exp_err});
      endcase
      @(negedge clk);
      obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, MD_Error};
      expv = sb.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL md_done step %0d: got %b expected %b", i, obs, expv);
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      if (i == 0) begin
        MulDiv_Start = 1'b1;
        MulDiv_Done  = 1'b1;
        sb.push_back({C_DEF, exp_err});
      end else begin
        IMem_Ready = 1'b0;
        sb.push_back({C_STALL, exp_err});
      end
      @(negedge clk);
      obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, MD_Error};
      expv = sb.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL start_done step %0d: got %b expected %b", i, obs, expv);
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_timeout();
    // Start cycle, then MD_TIMEOUT-1 held cycles, release on the last one
    for (int i = 0; i < 12; i++) begin
      set_idle();
      if (i == 0) begin
        MulDiv_Start = 1'b1;
        sb.push_back({C_DEF, exp_err});
      end else if (i < MD_TIMEOUT) begin
        sb.push_back({C_HOLD, exp_err});
      end else if (i == MD_TIMEOUT) begin
        sb.push_back({C_DEF, exp_err});
      end else if (i == MD_TIMEOUT + 2) begin
        set_lu(1'b1, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1);
        sb.push_back({C_STALL, exp_err});
      end else begin
        sb.push_back({C_DEF, exp_err});
      end
      @(negedge clk);
      obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, MD_Error};
      expv = sb.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL timeout step %0d: got %b expected %b", i, obs, expv);
      end
      next_cycle();
      if (i == MD_TIMEOUT) exp_err = 1'b1;
    end
    set_idle();
  endtask

  task automatic test_md_reset();
    for (int i = 0; i < 7; i++) begin
      set_idle();
      case (i)
        0: begin MulDiv_Start = 1'b1; sb.push_back({C_DEF, exp_err}); end
        4: begin rst = 1'b1; exp_err = 1'b0; Branch_Taken = 1'b1; sb.push_back({C_HOLD, exp_err}); end
        5: begin rst = 1'b0; sb.push_back({C_DEF, exp_err}); end
        6: begin IMem_Ready = 1'b0; sb.push_back({C_STALL, exp_err}); end
        default: sb.push_back({C_HOLD, exp_err});
      endcase
      @(negedge clk);
      obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, MD_Error};
      expv = sb.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL md_reset step %0d: got %b expected %b", i, obs, expv);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (i == 4 || i == 5) begin
        n_cmp++;
        if ({Stall_Cycles, Flush_Count} !== 64'd0) begin
          n_bad++;
          $display("FAIL perf_after_rst step %0d: got %0d/%0d expected 0/0", i, Stall_Cycles, Flush_Count);
        end
      end
`endif
      next_cycle();
    end
    set_idle();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_idle();
    Branch_Taken = 1'b1;
    next_cycle();
    set_idle();
    IMem_Ready = 1'b0;
    next_cycle();
    next_cycle();
    set_idle();
    @(negedge clk);
    n_cmp++;
    if (Stall_Cycles !== 32'd2) begin
      n_bad++;
      $display("FAIL perf_stall: got %0d expected 2", Stall_Cycles);
    end
    n_cmp++;
    if (Flush_Count !== 32'd1) begin
      n_bad++;
      $display("FAIL perf_flush: got %0d expected 1", Flush_Count);
    end
    next_cycle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_md_done();
    test_back_to_back();
    test_timeout();
    test_md_reset();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control block on the other end of the PC write-enable interface.
- Decides each cycle whether the PC and IF/ID registers may load, and whether IF/ID or ID/EX are flushed.
- Sources: load-use hazards, taken branches/jumps resolved in EX, multi-cycle mul/div occupancy, and instruction-memory wait.
- Single FSM plus timeout counter; outputs feed PC.PC_Write, the IF/ID register and the ID/EX register.

Parameters:
- REG_W, 5, register index width.
- MD_TIMEOUT, 64, max cycles in MD_WAIT before forced release.
- CNT_W, $clog2(MD_TIMEOUT+1), timeout counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- IFID_Rs1  in  REG_W  rs1 of instruction in ID.
- IFID_Rs2  in  REG_W  rs2 of instruction in ID.
- IFID_Rs1_Used  in  1  ID instruction reads rs1.
- IFID_Rs2_Used  in  1  ID instruction reads rs2.
- IDEX_MemRead  in  1  EX instruction is a load.
- IDEX_Rd  in  REG_W  destination of EX instruction.
- Branch_Taken  in  1  EX redirect (taken branch/JAL/JALR).
- MulDiv_Start  in  1  EX holds a mul/div starting this cycle.
- MulDiv_Done  in  1  mul/div result valid this cycle.
- IMem_Ready  in  1  instruction memory returned data for PC_Out.
- PC_Write  out  1  PC load enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  IF/ID becomes NOP.
- IDEX_Write  out  1  ID/EX load enable.
- IDEX_Flush  out  1  ID/EX becomes bubble.
- MD_Error  out  1  sticky flag: mul/div timeout occurred.

Behaviour:
- Reset: state=RUN, counter=0, MD_Error=0. While rst=1, PC_Write=IFID_Write=IDEX_Write=0 and both flushes=0.
- Outputs are combinational from state and current inputs (Mealy), zero latency. State, counter and MD_Error are registered.
- Load-use hazard (LU): IDEX_MemRead & IDEX_Rd!=0 & ((Rs1_Used & Rs1==IDEX_Rd) | (Rs2_Used & Rs2==IDEX_Rd)). x0 never hazards.
- Default (RUN, no event): PC_Write=IFID_Write=IDEX_Write=1, flushes=0.
- RUN priority, highest first:
  1. Branch_Taken: PC_Write=1, IFID_Flush=1, IDEX_Flush=1, IFID_Write=1, IDEX_Write=1. LU and IMem_Ready=0 are ignored this cycle.
  2. MulDiv_Start (no branch): next state MD_WAIT, counter cleared; outputs as default this cycle.
  3. LU: PC_Write=0, IFID_Write=0, IDEX_Flush=1.
  4. IMem_Ready=0: PC_Write=0, IFID_Write=0, IDEX_Flush=1.
- MD_WAIT:
  - MulDiv_Done=0: PC_Write=IFID_Write=IDEX_Write=0, flushes=0; counter+1.
  - MulDiv_Done=1: default outputs, next state RUN, counter cleared.
  - Counter==MD_TIMEOUT-1 without Done: MD_Error set next edge, next state RUN, outputs this cycle as Done=1.
  - Branch_Taken, LU and IMem_Ready are ignored in MD_WAIT.
- Counter saturates and never wraps. MD_Error clears only on rst.
- Reset asserted mid-MD_WAIT: immediate return to RUN, counter 0.
- MulDiv_Start and MulDiv_Done together in RUN: single-cycle op; remain in RUN.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit outputs Stall_Cycles (increments on every non-reset cycle with PC_Write=0) and Flush_Count (increments on each Branch_Taken flush). Both reset to 0 and wrap at 2^32.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package hazard_pkg: state enum (RUN=0, MD_WAIT=1) and REG_W default.
- One sub-module, hazard_lu_detect: the combinational load-use comparator (LU above), so forwarding logic can reuse it.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 -> one cycle with PC_Write=0, IFID_Write=0, IDEX_Flush=1; next cycle default.
- Load x0 in EX, ID rs1=x0 -> no stall, PC_Write=1.
- Branch_Taken=1 together with LU and IMem_Ready=0 -> PC_Write=1, IFID_Flush=1, IDEX_Flush=1.
- MulDiv_Start, Done after 5 cycles -> 5 cycles with all write enables 0, release in the Done cycle, MD_Error=0.
- MulDiv_Start, Done never asserted, MD_TIMEOUT=8 -> release after 8 cycles, MD_Error=1 until rst.
- rst pulsed at cycle 3 of MD_WAIT -> all enables 0 during rst; after release, default outputs in RUN; with HAZARD_PERF_CNT_EN, counters read 0.
